// File: rtl/uart_tx.sv
`timescale 1ns/1ps
// uart_tx: 8N1 UART transmitter fed by a small byte FIFO, LSB first, i_baud_div clocks per bit.
// Define UART_TX_PARITY_EN to insert a parity bit before stop (PARITY_ODD selects odd parity).
module uart_tx #(
   parameter int DATA_WIDTH     = 8,
   parameter int FIFO_DEPTH     = 4,
   parameter int BAUD_DIV_WIDTH = 16
`ifdef UART_TX_PARITY_EN
   ,
   parameter bit PARITY_ODD     = 1'b0
`endif
) (
   input  logic                      i_clk,
   input  logic                      i_rst,
   input  logic [DATA_WIDTH-1:0]     i_data,
   input  logic                      i_wr_n,
   input  logic [BAUD_DIV_WIDTH-1:0] i_baud_div,
   output logic                      o_tx,
   output logic                      o_busy,
   output logic                      o_full,
   output logic                      o_overflow,
   output logic                      o_done_n
);

   localparam int PTR_W = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
   localparam int CNT_W = PTR_W + 1;
   localparam int IDX_W = (DATA_WIDTH > 1) ? $clog2(DATA_WIDTH) : 1;
   localparam logic [CNT_W-1:0]          FULL_CNT = CNT_W'(FIFO_DEPTH);
   localparam logic [IDX_W-1:0]          LAST_BIT = IDX_W'(DATA_WIDTH - 1);
   localparam logic [BAUD_DIV_WIDTH-1:0] ONE      = BAUD_DIV_WIDTH'(1);

   localparam logic [2:0] S_IDLE   = 3'd0;
   localparam logic [2:0] S_START  = 3'd1;
   localparam logic [2:0] S_DATA   = 3'd2;
   localparam logic [2:0] S_STOP   = 3'd3;
`ifdef UART_TX_PARITY_EN
   localparam logic [2:0] S_PARITY = 3'd4;
`endif

   logic [DATA_WIDTH-1:0]     mem [FIFO_DEPTH];
   logic [PTR_W-1:0]          wr_ptr, rd_ptr;
   logic [CNT_W-1:0]          count;
   logic [2:0]                state;
   logic [BAUD_DIV_WIDTH-1:0] baud_reg, baud_cnt, baud_eff;
   logic [IDX_W-1:0]          bit_idx;
   logic [DATA_WIDTH-1:0]     shreg, head;
   logic                      fifo_empty, fifo_full, bit_end, pop, wr_en, tx_level;
`ifdef UART_TX_PARITY_EN
   logic                      parity_bit;
`endif

   assign fifo_empty = (count == '0);
   assign fifo_full  = (count == FULL_CNT);
   assign bit_end    = (baud_cnt == '0);
   // A pop happens from IDLE, or on the last stop cycle so the next frame follows with no gap.
   assign pop        = !fifo_empty && ((state == S_IDLE) || (state == S_STOP && bit_end));
   assign wr_en      = !i_wr_n && (!fifo_full || pop);
   assign baud_eff   = (i_baud_div == '0) ? ONE : i_baud_div;
   assign head       = mem[rd_ptr];
   assign o_full     = fifo_full;

   // NOTE: FIFO storage has no reset; the pointers and count alone define what is valid.
   always_ff @(posedge i_clk) begin
      if (wr_en) mem[wr_ptr] <= i_data;
   end

   // NOTE: sequential state uses non-blocking assignments so every register sees pre-edge values.
   always_ff @(posedge i_clk or posedge i_rst) begin
      if (i_rst) begin
         wr_ptr     <= '0;
         rd_ptr     <= '0;
         count      <= '0;
         o_overflow <= 1'b0;
      end else begin
         if (wr_en) wr_ptr <= wr_ptr + PTR_W'(1);
         if (pop)   rd_ptr <= rd_ptr + PTR_W'(1);
         if (wr_en && !pop)      count <= count + CNT_W'(1);
         else if (pop && !wr_en) count <= count - CNT_W'(1);
         if (!i_wr_n && fifo_full && !pop) o_overflow <= 1'b1;
      end
   end

   always_ff @(posedge i_clk or posedge i_rst) begin
      if (i_rst) begin
         state    <= S_IDLE;
         baud_reg <= ONE;
         baud_cnt <= '0;
         bit_idx  <= '0;
         shreg    <= '0;
`ifdef UART_TX_PARITY_EN
         parity_bit <= 1'b0;
`endif
      end else begin
         case (state)
            S_START: begin
               if (bit_end) begin
                  state    <= S_DATA;
                  baud_cnt <= baud_reg - ONE;
               end else begin
                  baud_cnt <= baud_cnt - ONE;
               end
            end
            S_DATA: begin
               if (bit_end) begin
                  baud_cnt <= baud_reg - ONE;
                  shreg    <= shreg >> 1;
                  if (bit_idx == LAST_BIT) begin
                     bit_idx <= '0;
`ifdef UART_TX_PARITY_EN
                     state   <= S_PARITY;
`else
                     state   <= S_STOP;
`endif
                  end else begin
                     bit_idx <= bit_idx + IDX_W'(1);
                  end
               end else begin
                  baud_cnt <= baud_cnt - ONE;
               end
            end
`ifdef UART_TX_PARITY_EN
            S_PARITY: begin
               if (bit_end) begin
                  state    <= S_STOP;
                  baud_cnt <= baud_reg - ONE;
               end else begin
                  baud_cnt <= baud_cnt - ONE;
               end
            end
`endif
            S_STOP: begin
               if (bit_end) state    <= S_IDLE;
               else         baud_cnt <= baud_cnt - ONE;
            end
            default: state <= S_IDLE;
         endcase

         // Frame load overrides the case above; the divider is captured only here.
         if (pop) begin
            state    <= S_START;
            shreg    <= head;
            baud_reg <= baud_eff;
            baud_cnt <= baud_eff - ONE;
            bit_idx  <= '0;
`ifdef UART_TX_PARITY_EN
            parity_bit <= (^head) ^ PARITY_ODD;
`endif
         end
      end
   end

   // NOTE: default assignment first keeps this combinational block from inferring a latch.
   always_comb begin
      tx_level = 1'b1;
      case (state)
         S_START:  tx_level = 1'b0;
         S_DATA:   tx_level = shreg[0];
`ifdef UART_TX_PARITY_EN
         S_PARITY: tx_level = parity_bit;
`endif
         default:  tx_level = 1'b1;
      endcase
   end

   // Line and status outputs are registered, so the line trails the state by one cycle.
   always_ff @(posedge i_clk or posedge i_rst) begin
      if (i_rst) begin
         o_tx     <= 1'b1;
         o_done_n <= 1'b1;
         o_busy   <= 1'b0;
      end else begin
         o_tx     <= tx_level;
         o_done_n <= !(state == S_STOP && bit_end);
         o_busy   <= (state != S_IDLE) || !fifo_empty;
      end
   end

endmodule
